tv80_bus_responder: RTL and testbench

Bus-side responder for the tv80_core master. Decodes the core's cycle strobes and serves internal RAM, a 4-register I/O bank and an IM2 interrupt vector. Drives di/dinst, wait_n and int_n back to the core. Sits beside the CPU core in the EP2C5 top and is the only slave on that bus.

---
 rtl/tv80_resp_pkg.sv | 13 +
 rtl/tv80_resp_ram.sv | 22 ++
 rtl/tv80_bus_responder.sv | 153 +++++++++++++++
 tb/tb_tv80_bus_responder.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/tv80_resp_pkg.sv
// Shared types and constants for the tv80 bus responder.
package tv80_resp_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, DATA, DONE} state_t;

  localparam logic [1:0] IO_OUT  = 2'd0;
  localparam logic [1:0] IO_IN   = 2'd1;
  localparam logic [1:0] IO_VEC  = 2'd2;
  localparam logic [1:0] IO_CTRL = 2'd3;

  localparam logic [7:0] OPEN_BUS = 8'hFF;

endpackage

// File: rtl/tv80_resp_ram.sv
// Single-port synchronous RAM with registered read; maps onto an M4K block.
module tv80_resp_ram #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/tv80_bus_responder.sv
// Bus slave for tv80_core: internal RAM, 4-register I/O bank and IM2 vector.
module tv80_bus_responder
  import tv80_resp_pkg::*;
#(
  parameter int          RAM_AW   = 10,
  parameter logic [15:0] RAM_BASE = 16'h8000,
  parameter logic [7:0]  IO_BASE  = 8'h10,
  parameter int          WAIT_MEM = 0,
  parameter int          WAIT_IO  = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cen,
  input  logic        m1_n,
  input  logic        iorq,
  input  logic        no_read,
  input  logic        write,
  input  logic        rfsh_n,
  input  logic        intcycle_n,
  input  logic [6:0]  ts,
  input  logic [15:0] A,
  input  logic [7:0]  dout,
  output logic [7:0]  di,
  output logic [7:0]  dinst,
  output logic        wait_n,
  output logic        int_n,
  input  logic        irq,
  output logic [7:0]  io_out,
  input  logic [7:0]  io_in,
  output state_t      fsm_state
);

  localparam logic [2:0] WAIT_MEM_C = 3'(WAIT_MEM);
  localparam logic [2:0] WAIT_IO_C  = 3'(WAIT_IO);

  state_t      state;
  logic [15:0] a_lat;
  logic        wr_lat, io_lat, nr_lat, inta_lat;
  logic [2:0]  wcnt;
  logic [7:0]  vec;
  logic        enable, pending;
  logic [2:0]  irq_sync;
  logic [7:0]  ram_q, io_rd;
  logic        ram_hit, io_hit, ram_we, pend_clr, irq_edge;
  logic [2:0]  wsel;
  logic [RAM_AW-1:0] ram_addr;
  logic        unused_ts;

  assign unused_ts = ^{ts[6:2], ts[0]};

  assign ram_hit  = (a_lat[15:RAM_AW] == RAM_BASE[15:RAM_AW]);
  assign io_hit   = (a_lat[7:2] == IO_BASE[7:2]);
  assign wsel     = iorq ? WAIT_IO_C : WAIT_MEM_C;
  assign irq_edge = irq_sync[1] & ~irq_sync[2];

  // Present the live address in IDLE so the registered read is ready by DATA.
  assign ram_addr = (state == IDLE) ? A[RAM_AW-1:0] : a_lat[RAM_AW-1:0];
  assign ram_we   = cen && (state == DATA) && !inta_lat && wr_lat && !io_lat && ram_hit;
  assign pend_clr = (state == DATA) &&
                    (inta_lat || (wr_lat && io_lat && io_hit && a_lat[1:0] == IO_CTRL && dout[1]));

  always_comb begin
    io_rd = OPEN_BUS;
    case (a_lat[1:0])
      IO_OUT:  io_rd = io_out;
      IO_IN:   io_rd = io_in;
      IO_VEC:  io_rd = vec;
      IO_CTRL: io_rd = {6'b0, pending, enable};
      default: io_rd = OPEN_BUS;
    endcase
  end

  tv80_resp_ram #(.AW(RAM_AW)) u_ram (
    .clk   (clk),
    .en    (cen),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (dout),
    .rdata (ram_q)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      a_lat    <= '0;
      wr_lat   <= 1'b0;
      io_lat   <= 1'b0;
      nr_lat   <= 1'b1;
      inta_lat <= 1'b0;
      wcnt     <= '0;
      di       <= OPEN_BUS;
      wait_n   <= 1'b1;
      io_out   <= '0;
      vec      <= 8'hFF;
      enable   <= 1'b0;
      pending  <= 1'b0;
      irq_sync <= '0;
    end else if (cen) begin
      irq_sync <= {irq_sync[1:0], irq};
      // A new edge outranks a clear landing on the same cen.
      if (irq_edge)      pending <= 1'b1;
      else if (pend_clr) pending <= 1'b0;

      case (state)
        IDLE: if (ts[1] && rfsh_n) begin
          a_lat    <= A;
          wr_lat   <= write;
          io_lat   <= iorq;
          nr_lat   <= no_read;
          inta_lat <= !intcycle_n && !m1_n && iorq;
          if (wsel != 3'd0) begin
            wcnt   <= wsel;
            wait_n <= 1'b0;
            state  <= WAIT;
          end else begin
            state  <= DATA;
          end
        end
        WAIT: if (wcnt == 3'd1) begin
          wait_n <= 1'b1;
          state  <= DATA;
        end else begin
          wcnt <= wcnt - 3'd1;
        end
        DATA: begin
          state <= DONE;
          if (inta_lat) begin
            di <= vec;
          end else if (wr_lat) begin
            if (io_lat && io_hit) begin
              case (a_lat[1:0])
                IO_OUT:  io_out <= dout;
                IO_VEC:  vec    <= dout;
                IO_CTRL: enable <= dout[0];
                default: ;
              endcase
            end
          end else if (!nr_lat) begin
            if (io_lat) di <= io_hit ? io_rd : OPEN_BUS;
            else        di <= ram_hit ? ram_q : OPEN_BUS;
          end
        end
        DONE: if (!ts[1]) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign dinst     = di;
  assign int_n     = ~(pending & enable);
  assign fsm_state = state;

endmodule

// File: tb/tb_tv80_bus_responder.sv
// Directed bench for tv80_bus_responder with a read-data scoreboard.
module tb_tv80_bus_responder;
  import tv80_resp_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cen_a, cen_b;
  logic        m1_n, iorq, no_read, write, rfsh_n, intcycle_n, irq;
  logic [6:0]  ts;
  logic [15:0] A;
  logic [7:0]  dout, io_in;
  logic [7:0]  di_a, dinst_a, io_out_a, di_b, dinst_b, io_out_b;
  logic        wait_n_a, int_n_a, wait_n_b, int_n_b;
  state_t      state_a, state_b;

  logic [7:0]  exp_q[$];
  string       tag_q[$];
  int          total = 0;
  int          bad   = 0;
  bit          use_a = 1'b1;
  bit          stall = 1'b0;
  int          wc;

  always #5 clk = ~clk;

  tv80_bus_responder #(.WAIT_IO(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .cen(cen_a), .m1_n(m1_n), .iorq(iorq),
    .no_read(no_read), .write(write), .rfsh_n(rfsh_n), .intcycle_n(intcycle_n),
    .ts(ts), .A(A), .dout(dout), .di(di_a), .dinst(dinst_a), .wait_n(wait_n_a),
    .int_n(int_n_a), .irq(irq), .io_out(io_out_a), .io_in(io_in), .fsm_state(state_a)
  );

  tv80_bus_responder #(.WAIT_IO(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .cen(cen_b), .m1_n(m1_n), .iorq(iorq),
    .no_read(no_read), .write(write), .rfsh_n(rfsh_n), .intcycle_n(intcycle_n),
    .ts(ts), .A(A), .dout(dout), .di(di_b), .dinst(dinst_b), .wait_n(wait_n_b),
    .int_n(int_n_b), .irq(irq), .io_out(io_out_b), .io_in(io_in), .fsm_state(state_b)
  );

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] di_sel();
    return use_a ? di_a : di_b;
  endfunction

  function automatic logic wait_sel();
    return use_a ? wait_n_a : wait_n_b;
  endfunction

  // One cen-qualified step; in stall mode a dead clock (cen=0) precedes it.
  task automatic tick();
    logic [7:0] held;
    if (stall) begin
      cen_a = 1'b0; cen_b = 1'b0;
      held = di_sel();
      @(posedge clk); #1;
      check("stall_hold_di", di_sel(), held);
    end
    cen_a = use_a; cen_b = !use_a;
    @(posedge clk); #1;
    cen_a = 1'b0; cen_b = 1'b0;
  endtask

  task automatic bus_idle();
    ts = 7'b0; m1_n = 1'b1; iorq = 1'b0; write = 1'b0; no_read = 1'b1;
    intcycle_n = 1'b1; rfsh_n = 1'b1;
  endtask

  task automatic bus_cycle(input logic io, input logic wr, input logic nr, input logic inta,
                           input logic [15:0] addr, input logic [7:0] data, output int wcount);
    A = addr; iorq = io; write = wr; no_read = nr; dout = data;
    m1_n = !inta; intcycle_n = !inta;
    ts = 7'b0000001; tick();
    ts = 7'b0000010; tick();
    wcount = 0;
    while (wait_sel() == 1'b0 && wcount < 16) begin
      tick();
      wcount++;
    end
    ts = 7'b0000100; tick();
    ts = 7'b0001000; tick();
    bus_idle();
    tick();
  endtask

  task automatic do_write(input logic io, input logic [15:0] addr, input logic [7:0] data,
                          input int exp_wait, input string tag);
    int w;
    bus_cycle(io, 1'b1, 1'b0, 1'b0, addr, data, w);
    check({tag, "_wait"}, 16'(w), 16'(exp_wait));
  endtask

  task automatic do_read(input logic io, input logic inta, input logic nr, input logic [15:0] addr,
                         input logic [7:0] exp, input int exp_wait, input string tag);
    int w;
    logic [7:0] e;
    string t;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
    bus_cycle(io, 1'b0, nr, inta, addr, 8'h00, w);
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check(t, 16'(di_sel()), 16'(e));
    check({t, "_dinst"}, 16'(use_a ? dinst_a : dinst_b), 16'(e));
    check({t, "_wait"}, 16'(w), 16'(exp_wait));
  endtask

  initial begin
    reset_n = 1'b0; cen_a = 1'b0; cen_b = 1'b0; irq = 1'b0; io_in = 8'hC3;
    A = '0; dout = '0;
    bus_idle();
    repeat (3) @(posedge clk);
    #1;
    check("rst_di", 16'(di_a), 16'hFF);
    check("rst_dinst", 16'(dinst_a), 16'hFF);
    check("rst_wait_n", 16'(wait_n_a), 16'h1);
    check("rst_int_n", 16'(int_n_a), 16'h1);
    check("rst_io_out", 16'(io_out_a), 16'h00);
    check("rst_state", 16'(state_a), 16'(IDLE));
    reset_n = 1'b1;
    tick();

    do_write(1'b1, 16'h0010, 8'h5A, 1, "io_wr_out");
    check("io_out_5a", 16'(io_out_a), 16'h5A);
    do_read(1'b1, 1'b0, 1'b0, 16'h0010, 8'h5A, 1, "io_rd_out");

    do_write(1'b0, 16'h8000, 8'hA5, 0, "mem_wr_8000");
    do_write(1'b0, 16'h83FF, 8'h3C, 0, "mem_wr_83ff");
    do_read(1'b0, 1'b0, 1'b0, 16'h8000, 8'hA5, 0, "mem_rd_8000");
    do_read(1'b0, 1'b0, 1'b0, 16'h83FF, 8'h3C, 0, "mem_rd_83ff");
    do_read(1'b0, 1'b0, 1'b0, 16'h8400, 8'hFF, 0, "mem_rd_8400");
    do_read(1'b1, 1'b0, 1'b0, 16'h0011, 8'hC3, 1, "io_rd_in");
    do_read(1'b0, 1'b0, 1'b1, 16'h8000, 8'hC3, 0, "no_read_hold");
    do_read(1'b1, 1'b0, 1'b0, 16'h0020, 8'hFF, 1, "io_rd_unmapped");

    do_write(1'b1, 16'h0012, 8'h40, 1, "io_wr_vec");
    do_write(1'b1, 16'h0013, 8'h01, 1, "io_wr_ctrl_en");
    irq = 1'b1;
    wc = 0;
    while (int_n_a == 1'b1 && wc < 3) begin
      tick();
      wc++;
    end
    check("irq_int_n_low", 16'(int_n_a), 16'h0);
    irq = 1'b0;
    do_read(1'b1, 1'b1, 1'b0, 16'h0000, 8'h40, 1, "inta_vec");
    check("inta_int_n_high", 16'(int_n_a), 16'h1);
    do_read(1'b1, 1'b0, 1'b0, 16'h0013, 8'h01, 1, "ctrl_after_inta");

    do_write(1'b1, 16'h0013, 8'h00, 1, "io_wr_ctrl_off");
    irq = 1'b1;
    repeat (4) tick();
    irq = 1'b0;
    repeat (3) tick();
    check("masked_int_n", 16'(int_n_a), 16'h1);
    do_read(1'b1, 1'b0, 1'b0, 16'h0013, 8'h02, 1, "ctrl_pending");
    do_write(1'b1, 16'h0013, 8'h02, 1, "io_wr_ctrl_clr");
    do_read(1'b1, 1'b0, 1'b0, 16'h0013, 8'h00, 1, "ctrl_cleared");

    use_a = 1'b0; stall = 1'b1;
    do_read(1'b1, 1'b0, 1'b0, 16'h0010, 8'h00, 3, "stall_io_rd");
    check("stall_a_idle", 16'(state_a), 16'(IDLE));
    use_a = 1'b1; stall = 1'b0;

    A = 16'h0010; iorq = 1'b1; write = 1'b1; no_read = 1'b0; dout = 8'h77;
    ts = 7'b0000001; tick();
    ts = 7'b0000010; tick();
    check("midrst_wait_low", 16'(wait_n_a), 16'h0);
    check("midrst_state_wait", 16'(state_a), 16'(WAIT));
    reset_n = 1'b0;
    #1;
    check("midrst_wait_n", 16'(wait_n_a), 16'h1);
    check("midrst_state", 16'(state_a), 16'(IDLE));
    check("midrst_io_out", 16'(io_out_a), 16'h00);
    @(posedge clk); #1;
    reset_n = 1'b1;
    bus_idle();
    repeat (3) tick();
    check("midrst_io_out_after", 16'(io_out_a), 16'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
